// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns EXU memory requests into arbiter bus transactions.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses without touching the bus.
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [2:0]  m_memop,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_memfinish
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    WR_ADDR = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    op_reg, op_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [3:0]    wstrb_reg, wstrb_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          err_reg, err_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [31:0]   wdata_rep;
  logic [3:0]    wstrb_calc;
  logic [31:0]   load_data;
  logic          op_legal;
  logic          misaligned;
  logic          timeout;

  // Store data replicated into every lane, strobes select the lanes actually written
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] = (req_op[1:0] == 2'b00) ? req_wdata[7:0] :
                                    (req_op[1:0] == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                                             req_wdata[8*gi +: 8];
      assign wstrb_calc[gi] = (req_op[1:0] == 2'b00) ? (req_addr[1:0] == 2'(gi)) :
                              (req_op[1:0] == 2'b01) ? (req_addr[1] == 1'(gi / 2)) :
                                                       1'b1;
    end
  endgenerate

  always_comb begin
    op_legal = 1'b0;
    if (req_wr) begin
      op_legal = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b010);
    end else begin
      op_legal = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b010) ||
                 (req_op == 3'b100) || (req_op == 3'b101);
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (req_op[1:0] == 2'b01) begin
      misaligned = req_addr[0];
    end else if (req_op[1:0] == 2'b10) begin
      misaligned = (req_addr[1:0] != 2'b00);
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // Lane extraction uses the registered address/op; op[2] selects zero extension
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = 32'h0;
    case (addr_reg[1:0])
      2'b00:   byte_sel = m_rdata[7:0];
      2'b01:   byte_sel = m_rdata[15:8];
      2'b10:   byte_sel = m_rdata[23:16];
      default: byte_sel = m_rdata[31:24];
    endcase
    half_sel = addr_reg[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (op_reg[1:0])
      2'b00:   load_data = {{24{byte_sel[7] & ~op_reg[2]}}, byte_sel};
      2'b01:   load_data = {{16{half_sel[15] & ~op_reg[2]}}, half_sel};
      default: load_data = m_rdata;
    endcase
  end

  assign timeout = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          op_next    = req_op;
          addr_next  = req_addr;
          wdata_next = req_wr ? wdata_rep : 32'h0;
          wstrb_next = 4'b0000;
          rdata_next = 32'h0;
          err_next   = 1'b0;
          cnt_next   = '0;
          if (!op_legal || misaligned) begin
            err_next   = 1'b1;
            state_next = RESP;
          end else if (req_wr) begin
            wstrb_next = wstrb_calc;
            state_next = WR_ADDR;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        cnt_next = cnt_reg + 1'b1;
        if (timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else if (m_arready && m_memfinish) begin
          rdata_next = load_data;
          state_next = RESP;
        end else if (m_arready) begin
          state_next = RD_WAIT;
        end
      end

      RD_WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else if (m_memfinish) begin
          rdata_next = load_data;
          state_next = RESP;
        end
      end

      WR_ADDR: begin
        cnt_next = cnt_reg + 1'b1;
        if (timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else if (m_awready && m_memfinish) begin
          state_next = RESP;
        end else if (m_awready) begin
          state_next = WR_WAIT;
        end
      end

      WR_WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else if (m_memfinish) begin
          state_next = RESP;
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= 3'b000;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      wstrb_reg <= 4'b0000;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign m_memop    = op_reg;
  assign m_araddr   = {addr_reg[31:2], 2'b00};
  assign m_awaddr   = {addr_reg[31:2], 2'b00};
  assign m_arvalid  = (state_reg == RD_ADDR);
  assign m_awvalid  = (state_reg == WR_ADDR);
  assign m_wdata    = wdata_reg;
  assign m_wstrb    = wstrb_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl (TIMEOUT_CYC = 8).
// Expectations follow LSU_MISALIGN_CHECK_EN when it is defined for the build.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [2:0]  m_memop;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic        m_arvalid, m_arready, m_awvalid, m_awready, m_memfinish;
  logic [3:0]  m_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_memop(m_memop), .m_araddr(m_araddr), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_awaddr(m_awaddr),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_memfinish(m_memfinish)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_wr    = wr;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_resp_done"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  // Load whose arbiter accepts and finishes in the first RD_ADDR cycle
  task automatic quick_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] bus_data, input logic [31:0] exp);
    issue(1'b0, op, addr, 32'h0);
    m_arready = 1'b1; m_memfinish = 1'b1; m_rdata = bus_data;
    step();
    m_arready = 1'b0; m_memfinish = 1'b0; m_rdata = 32'h0;
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_err"}, {31'b0, resp_err}, 32'd0);
    consume(tag);
    $display("txn %s addr=%h rdata=%h err=%0d", tag, addr, exp, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_op = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    m_arready = 1'b0; m_rdata = 32'h0; m_awready = 1'b0; m_memfinish = 1'b0;
    step();
    step();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_arvalid", {31'b0, m_arvalid}, 32'd0);
    check("rst_awvalid", {31'b0, m_awvalid}, 32'd0);
    check("rst_wstrb", {28'b0, m_wstrb}, 32'h0);
    check("rst_memop", {29'b0, m_memop}, 32'h0);
    check("rst_araddr", m_araddr, 32'h0);
    check("rst_wdata", m_wdata, 32'h0);
    rst = 1'b0;
    step();

    // LB with finish three cycles after arready
    issue(1'b0, 3'b000, 32'h8000_0003, 32'h0);
    check("lb_arvalid", {31'b0, m_arvalid}, 32'd1);
    check("lb_araddr", m_araddr, 32'h8000_0000);
    check("lb_req_ready", {31'b0, req_ready}, 32'd0);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    check("lb_arvalid_drop", {31'b0, m_arvalid}, 32'd0);
    step();
    step();
    m_memfinish = 1'b1; m_rdata = 32'h80FF_1234;
    check("lb_wait_no_resp", {31'b0, resp_valid}, 32'd0);
    step();
    m_memfinish = 1'b0; m_rdata = 32'h0;
    check("lb_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    check("lb_err", {31'b0, resp_err}, 32'd0);
    step();
    check("lb_hold_valid", {31'b0, resp_valid}, 32'd1);
    check("lb_hold_rdata", resp_rdata, 32'hFFFF_FF80);
    // A request offered while the response is consumed must not be taken
    req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b010; req_addr = 32'h100;
    consume("lb");
    req_valid = 1'b0;
    check("lb_no_overlap_accept", {31'b0, m_arvalid}, 32'd0);
    $display("txn lb addr=80000003 rdata=ffffff80 err=0");

    // SH with same-cycle awready and finish
    issue(1'b1, 3'b001, 32'h8000_0102, 32'h0000_BEEF);
    check("sh_awvalid", {31'b0, m_awvalid}, 32'd1);
    check("sh_awaddr", m_awaddr, 32'h8000_0100);
    check("sh_wdata", m_wdata, 32'hBEEF_BEEF);
    check("sh_wstrb", {28'b0, m_wstrb}, 32'hC);
    check("sh_memop", {29'b0, m_memop}, 32'h1);
    m_awready = 1'b1; m_memfinish = 1'b1;
    step();
    m_awready = 1'b0; m_memfinish = 1'b0;
    check("sh_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("sh_err", {31'b0, resp_err}, 32'd0);
    check("sh_rdata", resp_rdata, 32'h0);
    consume("sh");
    $display("txn sh addr=80000102 wdata=beefbeef wstrb=c err=0");

    // SB lane select
    issue(1'b1, 3'b000, 32'h0000_0021, 32'h0000_00A5);
    check("sb_wdata", m_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb", {28'b0, m_wstrb}, 32'h2);
    m_awready = 1'b1; m_memfinish = 1'b1;
    step();
    m_awready = 1'b0; m_memfinish = 1'b0;
    check("sb_err", {31'b0, resp_err}, 32'd0);
    consume("sb");
    $display("txn sb addr=00000021 wdata=a5a5a5a5 wstrb=2 err=0");

    // LW at 0x80000006: misaligned error or plain word read depending on build
    issue(1'b0, 3'b010, 32'h8000_0006, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lw_mis_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("lw_mis_err", {31'b0, resp_err}, 32'd1);
    check("lw_mis_arvalid", {31'b0, m_arvalid}, 32'd0);
    consume("lw_mis");
    $display("txn lw_mis addr=80000006 err=1");
`else
    check("lw_arvalid", {31'b0, m_arvalid}, 32'd1);
    check("lw_araddr", m_araddr, 32'h8000_0004);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    m_memfinish = 1'b1; m_rdata = 32'hCAFE_F00D;
    step();
    m_memfinish = 1'b0; m_rdata = 32'h0;
    check("lw_rdata", resp_rdata, 32'hCAFE_F00D);
    check("lw_err", {31'b0, resp_err}, 32'd0);
    consume("lw");
    $display("txn lw addr=80000006 rdata=cafef00d err=0");
`endif

    quick_load("lhu", 3'b101, 32'h0000_0010, 32'h8001_7FFE, 32'h0000_7FFE);
    quick_load("lh", 3'b001, 32'h0000_0012, 32'h8001_7FFE, 32'hFFFF_8001);
    quick_load("lbu", 3'b100, 32'h0000_0001, 32'h1234_F056, 32'h0000_00F0);

    // Timeout: arready never arrives
    issue(1'b0, 3'b010, 32'h8000_0000, 32'h0);
    for (int i = 1; i < 8; i++) begin
      check("to_arvalid_held", {31'b0, m_arvalid}, 32'd1);
      check("to_no_resp", {31'b0, resp_valid}, 32'd0);
      step();
    end
    check("to_arvalid_last", {31'b0, m_arvalid}, 32'd1);
    step();
    check("to_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("to_err", {31'b0, resp_err}, 32'd1);
    check("to_rdata", resp_rdata, 32'h0);
    check("to_arvalid_low", {31'b0, m_arvalid}, 32'd0);
    m_memfinish = 1'b1; m_rdata = 32'hFFFF_FFFF;
    step();
    m_memfinish = 1'b0; m_rdata = 32'h0;
    check("to_late_finish_rdata", resp_rdata, 32'h0);
    check("to_late_finish_err", {31'b0, resp_err}, 32'd1);
    consume("to");
    $display("txn timeout addr=80000000 err=1");

    // Reset pulse during WR_WAIT
    issue(1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678);
    check("sw_wstrb", {28'b0, m_wstrb}, 32'hF);
    check("sw_wdata", m_wdata, 32'h1234_5678);
    m_awready = 1'b1;
    step();
    m_awready = 1'b0;
    check("sw_wait_awvalid", {31'b0, m_awvalid}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_awvalid", {31'b0, m_awvalid}, 32'd0);
    check("mid_rst_wstrb", {28'b0, m_wstrb}, 32'h0);
    m_memfinish = 1'b1;
    step();
    m_memfinish = 1'b0;
    check("mid_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    $display("txn sw_reset addr=00000040 resp=none");

    // Illegal ops
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    check("ill_ld_resp_valid", {31'b0, resp_valid}, 32'd1);
    check("ill_ld_err", {31'b0, resp_err}, 32'd1);
    check("ill_ld_arvalid", {31'b0, m_arvalid}, 32'd0);
    consume("ill_ld");
    $display("txn illegal_load op=011 err=1");
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    check("ill_st_err", {31'b0, resp_err}, 32'd1);
    check("ill_st_awvalid", {31'b0, m_awvalid}, 32'd0);
    consume("ill_st");
    $display("txn illegal_store op=100 err=1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
